uart_tx: RTL and testbench

//   Serial transmitter stage that sits directly downstream of baud_gen and consumes
//   its tick_baud strobe. It accepts one parallel word per frame through a

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions, used by uart_tx and later by uart_rx.
//   tx_state_t  : transmitter FSM states
//   UART_*      : default frame format (8 data bits, no parity, 1 stop bit)
//   parity_bit  : parity of a data word (zero-extend narrower words); odd=1
//                 selects odd parity, odd=0 selects even parity
package uart_pkg;

  localparam int unsigned UART_DATA_BITS     = 8;
  localparam int unsigned UART_STOP_BITS     = 1;
  localparam int unsigned UART_PARITY_EN     = 0;
  localparam int unsigned UART_MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic parity_bit(input logic [UART_MAX_DATA_BITS-1:0] data,
                                      input logic                          odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serial transmitter, driven by the tick_baud strobe of baud_gen.
// A word is accepted through tx_ready/tx_start, then sent on tx as a start bit,
// DATA_BITS data bits LSB first, an optional parity bit and STOP_BITS stop
// bits. Every bit lasts exactly one tick interval; tx_done pulses for one
// cycle when the final stop bit completes.
// Ports:
//   clk       : system clock, all logic on posedge
//   rst       : synchronous reset, active-high
//   tick_baud : one-cycle strobe per bit period
//   tx_start  : send request, honoured only while tx_ready=1
//   tx_data   : word to send, sampled on the accept cycle only
//   tx_ready  : 1 while idle and able to accept a request
//   tx        : registered serial line, idle-high
//   tx_done   : one-cycle pulse at the end of the final stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned PARITY_EN  = UART_PARITY_EN,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = UART_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_baud,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done
);

  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [STOP_W-1:0]    stop_cnt, stop_n;
  logic                 par_q, par_n;
  logic                 tx_n, done_n, ready_n;

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    bit_n   = bit_cnt;
    stop_n  = stop_cnt;
    par_n   = par_q;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        // A coincident tick is deliberately not consumed here; SYNC waits
        // for the next one so the start bit is always full-length.
        if (tx_ready && tx_start) begin
          state_n = SYNC;
          shift_n = tx_data;
          par_n   = parity_bit(UART_MAX_DATA_BITS'(tx_data), PARITY_ODD != 0);
        end
      end
      SYNC: begin
        if (tick_baud) state_n = START;
      end
      START: begin
        if (tick_baud) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (tick_baud) begin
          shift_n = shift_q >> 1;
          if (bit_cnt == LAST_BIT) begin
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
            stop_n  = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick_baud) begin
          state_n = STOP;
          stop_n  = '0;
        end
      end
      STOP: begin
        if (tick_baud) begin
          if (stop_cnt == LAST_STOP) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level and ready are decoded from the next state so both are
    // registered and change on the same edge as the state itself.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state    <= state_n;
      shift_q  <= shift_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      par_q    <= par_n;
      tx       <= tx_n;
      tx_done  <= done_n;
      tx_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three frame formats (8N1, 8E2, 9O1) driven with a
// 1-in-16 tick strobe. Expected frames are queued on accept and compared by a
// bit-centre line monitor per instance.
module tb_uart_tx;

  localparam int unsigned NI = 3;
  localparam int unsigned NB   [NI] = '{8, 8, 9};
  localparam int unsigned PEN  [NI] = '{0, 1, 1};
  localparam int unsigned PODD [NI] = '{0, 0, 1};
  localparam int unsigned NSTP [NI] = '{1, 2, 1};

  typedef struct {
    logic [15:0] bits;
    int unsigned len;
    int unsigned fall;
    bit          abort;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rst_q = 1'b1;
  logic       rst_q2 = 1'b1;
  logic       start_r [NI];
  logic [8:0] data_r  [NI];
  logic       tx_w    [NI];
  logic       done_w  [NI];
  logic       ready_w [NI];
  bit         mon_act [NI];

  frame_t      exp_q [NI][$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_q  <= rst;
    rst_q2 <= rst_q;
  end

  // Tick on every posedge whose cycle number is a multiple of 16.
  always @(negedge clk) tick = ((cyc + 1) % 16 == 0);

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tick_baud(tick), .tx_start(start_r[0]),
    .tx_data(data_r[0][7:0]), .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_done(done_w[0]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tick_baud(tick), .tx_start(start_r[1]),
    .tx_data(data_r[1][7:0]), .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_done(done_w[1]));

  uart_tx #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tick_baud(tick), .tx_start(start_r[2]),
    .tx_data(data_r[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_done(done_w[2]));

  task automatic chk(input string name, input int g, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d at cycle %0d: got %0d expected %0d", name, g, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name, input int g);
    checks++;
    errors++;
    $display("FAIL %s inst%0d at cycle %0d", name, g, cyc);
  endtask

  // Frame as the line should carry it: start 0, data LSB first, optional
  // parity from the count of ones, then stop bits at 1.
  function automatic frame_t model(input int unsigned i, input logic [8:0] d,
                                   input int unsigned acc, input bit abort);
    frame_t      f;
    int unsigned pos  = 1;
    int unsigned ones = 0;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int unsigned b = 0; b < NB[i]; b++) begin
      f.bits[pos] = d[b];
      ones += int'(d[b]);
      pos++;
    end
    if (PEN[i] != 0) begin
      f.bits[pos] = ((ones + PODD[i]) % 2) == 1;
      pos++;
    end
    f.len   = pos + NSTP[i];
    f.fall  = (acc / 16 + 1) * 16;
    f.abort = abort;
    return f;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_mon
    initial begin
      frame_t      cur;
      int unsigned cnt = 0;
      mon_act[g] = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_q) begin
          chk("rst_tx", g, tx_w[g], 1);
          chk("rst_done", g, done_w[g], 0);
          chk("rst_ready", g, ready_w[g], 0);
          if (mon_act[g] && !cur.abort) fail("frame_cut_by_rst", g);
          mon_act[g] = 1'b0;
        end else if (!mon_act[g]) begin
          if (rst_q2) chk("ready_after_rst", g, ready_w[g], 1);
          if (done_w[g]) fail("unexpected_done", g);
          if (tx_w[g] == 1'b0) begin
            if (exp_q[g].size() == 0) begin
              fail("unexpected_frame", g);
              cur.bits = '1; cur.len = 1; cur.fall = cyc; cur.abort = 1'b0;
            end else begin
              cur = exp_q[g].pop_front();
              chk("start_time", g, cyc, cur.fall);
            end
            mon_act[g] = 1'b1;
            cnt = 0;
          end
        end else begin
          cnt++;
          if (cnt < 16 * cur.len && cnt % 16 == 8) begin
            chk($sformatf("bit%0d", cnt / 16), g, tx_w[g], cur.bits[cnt/16]);
            chk("busy_ready", g, ready_w[g], 0);
          end
          if (cnt == 16 * cur.len - 1) chk("done_early", g, done_w[g], 0);
          if (cnt == 16 * cur.len) begin
            chk("done", g, done_w[g], 1);
            chk("ready_at_done", g, ready_w[g], 1);
            if (cur.abort) fail("aborted_frame_completed", g);
            mon_act[g] = 1'b0;
          end
        end
      end
    end
  end

  // Waits at negedges for tx_ready (optionally also for a tick on the accept
  // edge), then holds tx_start for one edge and scrambles tx_data afterwards.
  task automatic send(input int unsigned i, input logic [8:0] d, input bit on_tick,
                      input bit abort, output int unsigned fall);
    int unsigned w = 0;
    frame_t      f;
    fall = 0;
    while (!(ready_w[i] && (!on_tick || ((cyc + 1) % 16 == 0)))) begin
      @(negedge clk);
      w++;
      if (w > 4000) begin
        fail("ready_timeout", int'(i));
        return;
      end
    end
    start_r[i] = 1'b1;
    data_r[i]  = d;
    f = model(i, d, cyc + 1, abort);
    fall = f.fall;
    exp_q[i].push_back(f);
    @(negedge clk);
    start_r[i] = 1'b0;
    data_r[i]  = 9'($urandom);
  endtask

  task automatic drain();
    int unsigned w = 0;
    bit busy = 1'b1;
    while (busy) begin
      busy = 1'b0;
      for (int i = 0; i < NI; i++)
        if (mon_act[i] || exp_q[i].size() != 0 || !ready_w[i]) busy = 1'b1;
      if (busy) begin
        @(negedge clk);
        w++;
        if (w > 5000) begin
          fail("drain_timeout", 0);
          busy = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int unsigned f;
    for (int i = 0; i < NI; i++) begin
      start_r[i] = 1'b0;
      data_r[i]  = '0;
    end

    // Reset for 3 edges; a request during reset must be ignored.
    @(negedge clk);
    start_r[1] = 1'b1;
    data_r[1]  = 9'h0FF;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    start_r[1] = 1'b0;
    @(negedge clk);

    // 8N1 0xA5
    send(0, 9'h0A5, 1'b0, 1'b0, f);
    drain();

    // Parity and two stop bits
    send(1, 9'h0A5, 1'b0, 1'b0, f);
    send(1, 9'h001, 1'b0, 1'b0, f);
    send(2, 9'h0A5, 1'b0, 1'b0, f);
    send(2, 9'h1FF, 1'b0, 1'b0, f);
    drain();

    // Mid-frame request ignored, then back-to-back request in the done cycle
    send(0, 9'h0A5, 1'b0, 1'b0, f);
    repeat (40) @(negedge clk);
    start_r[0] = 1'b1;
    data_r[0]  = 9'h0FF;
    repeat (3) @(negedge clk);
    start_r[0] = 1'b0;
    send(0, 9'h03C, 1'b0, 1'b0, f);
    drain();

    // Request coincident with a tick
    send(0, 9'h0C3, 1'b1, 1'b0, f);
    send(1, 9'h05A, 1'b1, 1'b0, f);
    drain();

    // Reset during data bit 4, then a clean frame
    send(0, 9'h0A5, 1'b0, 1'b1, f);
    while (cyc < f + 86) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 9'h05A, 1'b0, 1'b0, f);
    drain();

    // Randomized traffic
    for (int n = 0; n < 6; n++) begin
      for (int unsigned i = 0; i < NI; i++) begin
        send(i, 9'($urandom), 1'($urandom_range(0, 1)), 1'b0, f);
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
    end
    drain();

    for (int i = 0; i < NI; i++) chk("queue_empty", i, exp_q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
